// File: rtl/vga_fb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vga_fb_pkg
//  Purpose  : Shared constants for the pixel frame buffer and VGA scanout.
//             Holds 640x480@60 timing, frame-buffer geometry and the
//             16-entry palette used when VGA_PALETTE_EN is defined.
//  Revision : 1.0  initial release
// ============================================================================
package vga_fb_pkg;

    // Horizontal timing in 25 MHz pixel ticks.
    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    // Vertical timing in lines.
    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Frame-buffer geometry: each cell covers SCALE x SCALE screen pixels.
    localparam int H_CELLS  = 128;
    localparam int V_CELLS  = 96;
    localparam int SCALE    = 5;
    localparam int FB_WORDS = H_CELLS * V_CELLS;

    localparam int ADDR_W   = 14;
    localparam int COLOR_W  = 4;

    // CGA-style palette, 12'hRGB.
    localparam logic [11:0] PALETTE [16] = '{
        12'h000, 12'h00A, 12'h0A0, 12'h0AA,
        12'hA00, 12'hA0A, 12'hA50, 12'hAAA,
        12'h555, 12'h55F, 12'h5F5, 12'h5FF,
        12'hF55, 12'hF5F, 12'hFF5, 12'hFFF
    };

endpackage
`default_nettype wire

// File: rtl/vga_fb_ram.sv
`default_nettype none
// ============================================================================
//  Module   : vga_fb_ram
//  Purpose  : 12288 x 4 simple dual-port frame buffer. One write port and one
//             registered, enabled read port on the same clock; a read of an
//             address being written returns the old contents.
//  Revision : 1.0  initial release
// ============================================================================
module vga_fb_ram
    import vga_fb_pkg::*;
(
    input  logic               clk,
    input  logic               i_we,
    input  logic [ADDR_W-1:0]  i_waddr,
    input  logic [COLOR_W-1:0] i_wdata,
    input  logic               i_re,
    input  logic [ADDR_W-1:0]  i_raddr,
    output logic [COLOR_W-1:0] o_rdata
);

    logic [COLOR_W-1:0] r_mem [FB_WORDS];
    logic [COLOR_W-1:0] r_rdata;

    // Write and read in one block so the read samples pre-write contents.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/vga_fb_scanout.sv
`default_nettype none
// ============================================================================
//  Module   : vga_fb_scanout
//  Purpose  : Captures pixel PIO writes into a 128x96x4 frame buffer and scans
//             it out as 640x480@60 VGA with 5x5 cell replication.
//             Build option: VGA_PALETTE_EN selects the 16-entry palette;
//             without it the colour index drives R, G and B as grey scale.
//  Revision : 1.0  initial release
// ============================================================================
module vga_fb_scanout
    import vga_fb_pkg::*;
(
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic [13:0] pxl_addr_in,
    input  logic [3:0]  pxl_data_in,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        frame_tick
);

    localparam logic [9:0]        c_H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]        c_V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0]        c_H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0]        c_V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0]        c_HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0]        c_HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0]        c_VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]        c_VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [2:0]        c_SUB_LAST = 3'(SCALE - 1);
    localparam logic [ADDR_W-1:0] c_FB_LIMIT = ADDR_W'(FB_WORDS);

    // ------------------------------------------------------------------
    // Write capture
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0]  r_cap_addr;
    logic [COLOR_W-1:0] r_cap_data;
    logic [ADDR_W-1:0]  r_prev_addr;
    logic [COLOR_W-1:0] r_prev_data;
    logic               r_we;
    logic [ADDR_W-1:0]  r_waddr;
    logic [COLOR_W-1:0] r_wdata;

    // Register the PIO pair, keep the previous copy, and write once per change.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_cap_addr  <= '0;
            r_cap_data  <= '0;
            r_prev_addr <= '0;
            r_prev_data <= '0;
            r_we        <= 1'b0;
            r_waddr     <= '0;
            r_wdata     <= '0;
        end else begin
            r_cap_addr  <= pxl_addr_in;
            r_cap_data  <= pxl_data_in;
            r_prev_addr <= r_cap_addr;
            r_prev_data <= r_cap_data;
            r_we        <= ({r_cap_addr, r_cap_data} != {r_prev_addr, r_prev_data})
                           && (r_cap_addr < c_FB_LIMIT);
            r_waddr     <= r_cap_addr;
            r_wdata     <= r_cap_data;
        end
    end

    // ------------------------------------------------------------------
    // Pixel timing: counters advance only on pix_en, i.e. every other clk
    // ------------------------------------------------------------------
    logic       r_pix_en;
    logic [9:0] r_h;
    logic [9:0] r_v;
    logic [2:0] r_hsub;
    logic [6:0] r_hcell;
    logic [2:0] r_vsub;
    logic [6:0] r_vcell;

    // Raster counters with per-axis cell sub-counters (no division needed).
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_pix_en <= 1'b0;
            r_h      <= '0;
            r_v      <= '0;
            r_hsub   <= '0;
            r_hcell  <= '0;
            r_vsub   <= '0;
            r_vcell  <= '0;
        end else begin
            r_pix_en <= ~r_pix_en;
            if (r_pix_en) begin
                if (r_h == c_H_LAST) begin
                    r_h     <= '0;
                    r_hsub  <= '0;
                    r_hcell <= '0;
                    if (r_v == c_V_LAST) begin
                        r_v     <= '0;
                        r_vsub  <= '0;
                        r_vcell <= '0;
                    end else begin
                        r_v <= r_v + 10'd1;
                        if (r_vsub == c_SUB_LAST) begin
                            r_vsub  <= '0;
                            r_vcell <= r_vcell + 7'd1;
                        end else begin
                            r_vsub <= r_vsub + 3'd1;
                        end
                    end
                end else begin
                    r_h <= r_h + 10'd1;
                    if (r_hsub == c_SUB_LAST) begin
                        r_hsub  <= '0;
                        r_hcell <= r_hcell + 7'd1;
                    end else begin
                        r_hsub <= r_hsub + 3'd1;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Readout pipeline: stage 0 address, stage 1 RAM, stage 2 colour
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0]  w_rd_addr;
    logic [COLOR_W-1:0] w_rd_data;
    logic               w_active;
    logic               w_hs_n;
    logic               w_vs_n;
    logic               w_sof;
    logic [11:0]        w_rgb;

    assign w_rd_addr = {r_vcell, 7'b0} + {7'b0, r_hcell};
    assign w_active  = (r_h < c_H_ACT) && (r_v < c_V_ACT);
    assign w_hs_n    = !((r_h >= c_HS_START) && (r_h < c_HS_END));
    assign w_vs_n    = !((r_v >= c_VS_START) && (r_v < c_VS_END));
    assign w_sof     = (r_h == 10'd0) && (r_v == 10'd0);

    // The read port is enabled only on pix_en so the data stays paired with
    // the counter value that addressed it until stage 2 consumes it.
    vga_fb_ram u_ram (
        .clk     (clk_clk),
        .i_we    (r_we),
        .i_waddr (r_waddr),
        .i_wdata (r_wdata),
        .i_re    (r_pix_en),
        .i_raddr (w_rd_addr),
        .o_rdata (w_rd_data)
    );

`ifdef VGA_PALETTE_EN
    assign w_rgb = PALETTE[w_rd_data];
`else
    assign w_rgb = {w_rd_data, w_rd_data, w_rd_data};
`endif

    logic        r_act_d1;
    logic        r_hs_d1;
    logic        r_vs_d1;
    logic        r_sof_d1;
    logic [11:0] r_rgb;
    logic        r_hs;
    logic        r_vs;
    logic        r_frame_tick;

    // Delay sync/active/start-of-frame alongside the RAM read, then register pins.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_act_d1     <= 1'b0;
            r_hs_d1      <= 1'b1;
            r_vs_d1      <= 1'b1;
            r_sof_d1     <= 1'b0;
            r_rgb        <= '0;
            r_hs         <= 1'b1;
            r_vs         <= 1'b1;
            r_frame_tick <= 1'b0;
        end else begin
            r_frame_tick <= r_pix_en && r_sof_d1;
            if (r_pix_en) begin
                r_act_d1 <= w_active;
                r_hs_d1  <= w_hs_n;
                r_vs_d1  <= w_vs_n;
                r_sof_d1 <= w_sof;
                r_rgb    <= r_act_d1 ? w_rgb : 12'h000;
                r_hs     <= r_hs_d1;
                r_vs     <= r_vs_d1;
            end
        end
    end

    assign vga_r      = r_rgb[11:8];
    assign vga_g      = r_rgb[7:4];
    assign vga_b      = r_rgb[3:0];
    assign vga_hs     = r_hs;
    assign vga_vs     = r_vs;
    assign frame_tick = r_frame_tick;

endmodule
`default_nettype wire

// File: tb/tb_vga_fb_scanout.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vga_fb_scanout
//  Purpose  : Directed self-checking bench for vga_fb_scanout: reset state,
//             sync timing, write capture rules and on-screen cell placement.
//             Screen position P = y*800+x reaches the pins 2*P+4 clk after
//             reset release (2 clk per pixel plus the 4 clk pipeline).
//  Revision : 1.0  initial release
// ============================================================================
module tb_vga_fb_scanout;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [13:0] addr = '0;
    logic [3:0]  data = '0;
    logic [3:0]  vga_r;
    logic [3:0]  vga_g;
    logic [3:0]  vga_b;
    logic        vga_hs;
    logic        vga_vs;
    logic        frame_tick;

    int n_run  = 0;
    int n_fail = 0;
    int k      = 0;   // clk cycles since last reset release
    int we_cnt = 0;   // RAM write pulses observed

    localparam logic [11:0] c_PAL [16] = '{
        12'h000, 12'h00A, 12'h0A0, 12'h0AA, 12'hA00, 12'hA0A, 12'hA50, 12'hAAA,
        12'h555, 12'h55F, 12'h5F5, 12'h5FF, 12'hF55, 12'hF5F, 12'hFF5, 12'hFFF
    };

    vga_fb_scanout dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .pxl_addr_in   (addr),
        .pxl_data_in   (data),
        .vga_r         (vga_r),
        .vga_g         (vga_g),
        .vga_b         (vga_b),
        .vga_hs        (vga_hs),
        .vga_vs        (vga_vs),
        .frame_tick    (frame_tick)
    );

    always #10 clk = ~clk;

    function automatic logic [11:0] exp_rgb(input logic [3:0] idx);
`ifdef VGA_PALETTE_EN
        return c_PAL[idx];
`else
        return {idx, idx, idx};
`endif
    endfunction

    // Advance one clk, sampling on the falling edge.
    task automatic step();
        @(negedge clk);
        k++;
        if (dut.r_we === 1'b1) we_cnt++;
    endtask

    task automatic apply_reset(input int n);
        rst_n = 1'b0;
        repeat (n) step();
        rst_n = 1'b1;
        k = 0;
    endtask

    task automatic hold(input logic [13:0] a, input logic [3:0] d, input int n);
        addr = a;
        data = d;
        repeat (n) step();
    endtask

    task automatic test_reset();
        repeat (3) step();
        n_run++;
        if (vga_hs !== 1'b1) begin n_fail++; $display("FAIL reset_hs: got %b expected 1", vga_hs); end
        n_run++;
        if (vga_vs !== 1'b1) begin n_fail++; $display("FAIL reset_vs: got %b expected 1", vga_vs); end
        n_run++;
        if ({vga_r, vga_g, vga_b} !== 12'h000) begin
            n_fail++; $display("FAIL reset_rgb: got %h expected 000", {vga_r, vga_g, vga_b});
        end
        n_run++;
        if (frame_tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick: got %b expected 0", frame_tick); end
        rst_n = 1'b1;
        k = 0;
    endtask

    // Called right after a reset release; observes the first two lines.
    task automatic test_timing(input string tag);
        int ft_k = -1, ft_cnt = 0, fall1 = -1, fall2 = -1, low_len = 0;
        logic prev_hs = 1'b1, vs_low = 1'b0, hs_at1 = 1'b0;
        while (k < 3000) begin
            step();
            if (k == 1) hs_at1 = vga_hs;
            if (frame_tick === 1'b1) begin ft_cnt++; if (ft_k < 0) ft_k = k; end
            if (vga_vs !== 1'b1) vs_low = 1'b1;
            if (prev_hs === 1'b1 && vga_hs === 1'b0) begin
                if (fall1 < 0) fall1 = k;
                else if (fall2 < 0) fall2 = k;
            end
            if (vga_hs === 1'b0 && fall1 >= 0 && fall2 < 0) low_len++;
            prev_hs = vga_hs;
        end
        n_run++;
        if (hs_at1 !== 1'b1) begin n_fail++; $display("FAIL %s_hs_idle: got %b expected 1", tag, hs_at1); end
        n_run++;
        if (ft_k != 4) begin n_fail++; $display("FAIL %s_tick_pos: got %0d expected 4", tag, ft_k); end
        n_run++;
        if (ft_cnt != 1) begin n_fail++; $display("FAIL %s_tick_cnt: got %0d expected 1", tag, ft_cnt); end
        n_run++;
        if (fall1 - ft_k != 1312) begin
            n_fail++; $display("FAIL %s_hs_first: got %0d expected 1312", tag, fall1 - ft_k);
        end
        n_run++;
        if (low_len != 192) begin n_fail++; $display("FAIL %s_hs_width: got %0d expected 192", tag, low_len); end
        n_run++;
        if (fall2 - fall1 != 1600) begin
            n_fail++; $display("FAIL %s_line: got %0d expected 1600", tag, fall2 - fall1);
        end
        n_run++;
        if (vs_low !== 1'b0) begin n_fail++; $display("FAIL %s_vs_early: got %b expected 0", tag, vs_low); end
    endtask

    task automatic test_capture();
        we_cnt = 0;
        hold(14'd0, 4'hF, 6);
        n_run++;
        if (we_cnt != 1) begin n_fail++; $display("FAIL first_write: got %0d expected 1", we_cnt); end
        we_cnt = 0;
        hold(14'd0, 4'hF, 20);
        n_run++;
        if (we_cnt != 0) begin n_fail++; $display("FAIL no_change: got %0d expected 0", we_cnt); end
        we_cnt = 0;
        hold(14'd130, 4'h3, 100);
        n_run++;
        if (we_cnt != 1) begin n_fail++; $display("FAIL hold_once: got %0d expected 1", we_cnt); end
        we_cnt = 0;
        hold(14'd12288, 4'h7, 10);
        n_run++;
        if (we_cnt != 0) begin n_fail++; $display("FAIL oob_drop: got %0d expected 0", we_cnt); end
        we_cnt = 0;
        hold(14'd2, 4'h1, 1);
        hold(14'd3, 4'h2, 1);
        hold(14'd4, 4'h5, 1);
        hold(14'd4, 4'h5, 6);
        n_run++;
        if (we_cnt != 3) begin n_fail++; $display("FAIL back_to_back: got %0d expected 3", we_cnt); end
        hold(14'd1, 4'h6, 4);
        hold(14'd128, 4'h4, 4);
        hold(14'd60, 4'hA, 4);
    endtask

    // Restart the scan and check individual screen pixels of the first rows.
    task automatic test_display();
        int xs [13] = '{0, 4, 5, 9, 10, 14, 15, 20, 700, 4, 4, 10, 14};
        int ys [13] = '{0, 0, 0, 0,  0,  0,  0,  0,   0, 4, 5,  5,  9};
        logic [3:0] es [13] = '{4'hF, 4'hF, 4'h6, 4'h6, 4'h1, 4'h1, 4'h2, 4'h5,
                                4'h0, 4'hF, 4'h4, 4'h3, 4'h3};
        logic [11:0] want;
        int tgt;
        apply_reset(2);
        for (int i = 0; i < 13; i++) begin
            tgt = 2 * (ys[i] * 800 + xs[i]) + 4;
            while (k < tgt) step();
            want = exp_rgb(es[i]);
            if (xs[i] >= 640) want = 12'h000;
            n_run++;
            if ({vga_r, vga_g, vga_b} !== want) begin
                n_fail++;
                $display("FAIL pixel(%0d,%0d): got %h expected %h", xs[i], ys[i],
                         {vga_r, vga_g, vga_b}, want);
            end
        end
    endtask

    task automatic test_midline_reset();
        apply_reset(2);
        while (k < 604) step();
        n_run++;
        if ({vga_r, vga_g, vga_b} !== exp_rgb(4'hA)) begin
            n_fail++; $display("FAIL mid_pixel: got %h expected %h", {vga_r, vga_g, vga_b}, exp_rgb(4'hA));
        end
        rst_n = 1'b0;
        #1;
        n_run++;
        if ({vga_r, vga_g, vga_b, vga_hs, vga_vs, frame_tick} !== {12'h000, 3'b110}) begin
            n_fail++;
            $display("FAIL mid_idle: got %h/%b%b%b expected 000/110", {vga_r, vga_g, vga_b},
                     vga_hs, vga_vs, frame_tick);
        end
        repeat (2) step();
        rst_n = 1'b1;
        k = 0;
        test_timing("restart");
    endtask

    initial begin
        test_reset();
        test_timing("first");
        test_capture();
        test_display();
        test_midline_reset();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
